// File: rtl/run_seq_pkg.sv
// Shared state encodings and flag codes for the run sequencer.
// Imported by the top-level FSM and by its state-to-flag decoder.
package run_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] FLAG_HOLD = 2'd2;
    localparam logic [1:0] FLAG_RUN  = 2'd1;
    localparam logic [1:0] FLAG_CLR  = 2'd0;

endpackage

// File: rtl/state_flag_decode.sv
// Purely combinational state-to-flag decode. Every 2-bit state value maps to a
// defined flag, so the decode can never infer storage.
module state_flag_decode
    import run_seq_pkg::*;
(
    input  logic [1:0] state,
    output logic [1:0] flag
);

    always_comb begin
        flag = FLAG_HOLD;
        case (state)
            S_IDLE:  flag = FLAG_HOLD;
            S_ARM:   flag = FLAG_HOLD;
            S_RUN:   flag = FLAG_RUN;
            S_DONE:  flag = FLAG_CLR;
            default: flag = FLAG_HOLD;
        endcase
    end

endmodule

// File: rtl/run_sequencer.sv
// Four-phase idle/arm/run/done sequencer with per-operation run length and abort.
// The flag is registered from the decode of next-state so it tracks curr_state.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int ARM_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] run_len,
    output logic [1:0]       curr_state,
    output logic [1:0]       flag,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYCLES - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_next;
    logic [CNT_W-1:0] run_last;
    logic [1:0]       flag_reg;
    logic [1:0]       flag_next;

    // Only evaluated in RUN, which is never entered with len_q == 0.
    assign run_last = len_q - CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        len_next   = len_q;
        case (state_reg)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next = S_ARM;
                    len_next   = run_len;
                end
            end
            S_ARM: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == ARM_LAST) begin
                    state_next = (len_q == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == run_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Counter only advances while ARM or RUN is held; any state change clears it.
    always_comb begin
        cnt_next = '0;
        if ((state_next == state_reg) && ((state_reg == S_ARM) || (state_reg == S_RUN))) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    state_flag_decode u_decode (
        .state (state_next),
        .flag  (flag_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            len_q     <= '0;
            flag_reg  <= FLAG_HOLD;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            len_q     <= len_next;
            flag_reg  <= flag_next;
        end
    end

    assign curr_state = state_reg;
    assign flag       = flag_reg;
    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign cnt        = cnt_reg;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: a cycle model pushes expected outputs as
// stimulus is applied; they are popped and compared after the next clock edge.
module tb_run_sequencer;

    localparam int CNT_W = 8;
    localparam int ARM   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] run_len;
    logic [1:0]       curr_state;
    logic [1:0]       flag;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;

    run_sequencer #(.CNT_W(CNT_W), .ARM_CYCLES(ARM)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .run_len    (run_len),
        .curr_state (curr_state),
        .flag       (flag),
        .busy       (busy),
        .done       (done),
        .cnt        (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       st;
        logic [1:0]       fl;
        logic             bz;
        logic             dn;
        logic [CNT_W-1:0] ct;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]       m_st;
    logic [CNT_W-1:0] m_cnt;
    logic [CNT_W-1:0] m_len;
    int               done_seen;
    logic             saw_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [1:0] flag_of(input logic [1:0] st);
        case (st)
            2'd2:    return 2'd1;
            2'd3:    return 2'd0;
            default: return 2'd2;
        endcase
    endfunction

    // Applies one cycle of stimulus, advances the model, then checks after the edge.
    task automatic step(input logic s, input logic a, input logic r, input logic [CNT_W-1:0] len);
        logic [1:0]       ns;
        logic [CNT_W-1:0] nlen;
        exp_t             e;
        start   = s;
        abort   = a;
        rst     = r;
        run_len = len;
        if (r) begin
            m_st  = 2'd0;
            m_cnt = '0;
            m_len = '0;
        end else begin
            ns   = m_st;
            nlen = m_len;
            case (m_st)
                2'd0: if (s && !a) begin ns = 2'd1; nlen = len; end
                2'd1: if (a) ns = 2'd0;
                      else if (m_cnt == CNT_W'(ARM - 1)) ns = (m_len == 0) ? 2'd3 : 2'd2;
                2'd2: if (a) ns = 2'd0;
                      else if (m_cnt + 1 == m_len) ns = 2'd3;
                default: ns = 2'd0;
            endcase
            if (ns == m_st && (m_st == 2'd1 || m_st == 2'd2)) m_cnt = m_cnt + 1;
            else m_cnt = '0;
            m_st  = ns;
            m_len = nlen;
        end
        e.st = m_st;
        e.fl = flag_of(m_st);
        e.bz = (m_st != 2'd0);
        e.dn = (m_st == 2'd3);
        e.ct = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("state", 32'(curr_state), 32'(e.st));
        check("flag",  32'(flag),       32'(e.fl));
        check("busy",  32'(busy),       32'(e.bz));
        check("done",  32'(done),       32'(e.dn));
        check("cnt",   32'(cnt),        32'(e.ct));
        if (done) done_seen++;
        if (curr_state == 2'd2) saw_run = 1'b1;
        $display("t=%0t s=%0b a=%0b r=%0b len=%0d -> state=%0d flag=%0d busy=%0b done=%0b cnt=%0d",
                 $time, s, a, r, len, curr_state, flag, busy, done, cnt);
    endtask

    logic [1:0] seq_st[8];
    logic [1:0] seq_fl[8];

    initial begin
        seq_st = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        seq_fl = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2};
        start = 0; abort = 0; rst = 1; run_len = '0;
        done_seen = 0;
        saw_run = 1'b0;
        @(negedge clk);

        // Reset and idle
        step(0, 0, 1, 8'd0);
        step(0, 0, 1, 8'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'd0);

        // Nominal run of 4, with literal sequence checks
        step(1, 0, 0, 8'd4);
        for (int i = 0; i < 8; i++) begin
            check("seq_state", 32'(curr_state), 32'(seq_st[i]));
            check("seq_flag",  32'(flag),       32'(seq_fl[i]));
            check("seq_done",  32'(done),       32'(i == 6));
            step(0, 0, 0, 8'd0);
        end

        // Zero run length skips RUN
        saw_run = 1'b0;
        done_seen = 0;
        step(1, 0, 0, 8'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'd0);
        check("len0_no_run", 32'(saw_run), 32'd0);
        check("len0_done_cnt", 32'(done_seen), 32'd1);

        // Abort in the second RUN cycle
        done_seen = 0;
        step(1, 0, 0, 8'd10);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd0);
        step(0, 1, 0, 8'd0);
        check("abort_idle", 32'(curr_state), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd0);
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Held start relaunches every ARM+N+2 cycles; run_len noise outside IDLE
        done_seen = 0;
        for (int i = 0; i < 15; i++)
            step(1, 0, 0, (m_st == 2'd0) ? 8'd1 : CNT_W'($urandom_range(0, 255)));
        check("relaunch_done_cnt", 32'(done_seen), 32'd3);
        step(0, 0, 0, 8'd0);
        while (m_st != 2'd0) step(0, 0, 0, 8'd0);

        // Reset mid-RUN, then start+abort together in IDLE
        step(1, 0, 0, 8'd10);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd0);
        step(0, 0, 1, 8'd0);
        step(1, 1, 0, 8'd5);
        check("start_abort_idle", 32'(curr_state), 32'd0);
        step(0, 0, 0, 8'd0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) == 0), CNT_W'($urandom_range(0, 6)));

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Sequencing controller that owns the 2-bit `curr_state` register and its fully decoded `flag` output, driving a four-phase idle/arm/run/done cycle on request. It sits in front of any datapath that is gated by `flag`. It guarantees every state value decodes to a defined `flag`, so synthesis infers no latches. Run length is loaded per operation, and the operation can be aborted.

## Interface
- `CNT_W`, default 8: width of the run-length and cycle counter.
- `ARM_CYCLES`, default 2: number of cycles spent in ARM; legal range is 1 to 2^CNT_W-1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request to begin an operation; sampled only in IDLE.
- `abort` in 1: cancels an operation in ARM or RUN.
- `run_len` in CNT_W: number of RUN cycles; captured on the cycle `start` is accepted.
- `curr_state` out 2: registered state (0=IDLE, 1=ARM, 2=RUN, 3=DONE).
- `flag` out 2: registered decode of `curr_state` (IDLE→2, ARM→2, RUN→1, DONE→0).
- `busy` out 1: high whenever `curr_state` ≠ IDLE.
- `done` out 1: high for exactly the one cycle spent in DONE.
- `cnt` out CNT_W: in-state cycle counter, exposed for debug.

## Operation
- Reset values: `curr_state`=0, `flag`=2, `busy`=0, `done`=0, `cnt`=0, internal `len_q`=0.
- A reset asserted mid-operation returns all outputs to their reset values on the next edge. No `done` pulse is produced.
- `cnt` clears to 0 on every state change. It increments once per cycle while the state is held in ARM or RUN.
- IDLE:
  - `start`=1 and `abort`=0: capture `run_len` into `len_q` and go to ARM.
  - Otherwise stay in IDLE.
  - `start` and `abort` together in IDLE: `abort` wins and the block stays in IDLE.
- ARM:
  - `abort`: go to IDLE.
  - Else if `cnt`==ARM_CYCLES-1: go to RUN, or go straight to DONE when `len_q`==0.
  - Otherwise stay in ARM.
- RUN:
  - `abort`: go to IDLE.
  - Else if `cnt`==`len_q`-1: go to DONE.
  - Otherwise stay in RUN.
- DONE: unconditionally go to IDLE after one cycle; `abort` is ignored.
- `start` is ignored outside IDLE and is not queued. A held `start` relaunches from IDLE on the cycle after DONE.
- `abort` has priority over terminal-count exits.
- `flag` is registered from the decode of next-state, so it always matches `curr_state` in the same cycle.
- The decode is complete, with a default branch; default next-state is IDLE and default `flag` is 2.
- Counter arithmetic is unsigned, CNT_W wide, and never wraps within legal ranges.

## Timing
- With `start` accepted at edge t:
  - ARM at t+1.
  - RUN at t+1+ARM_CYCLES.
  - DONE at t+1+ARM_CYCLES+N, where N=`run_len`.
  - IDLE at the following edge.
- Start-to-`done` latency is 1+ARM_CYCLES+N cycles. With N=0 it is 1+ARM_CYCLES.
- `abort` sampled at edge t gives IDLE at t+1; `busy` falls at t+1.
- Back-to-back operations: minimum spacing is ARM_CYCLES+N+2 cycles between accepted starts.
- All outputs are registered or derived from registered state only; no input-to-output combinational path.

## Structure
- Shared package `run_seq_pkg` holds:
  - State constants `S_IDLE`, `S_ARM`, `S_RUN`, `S_DONE`.
  - Flag codes `FLAG_HOLD`=2, `FLAG_RUN`=1, `FLAG_CLR`=0.
- One sub-module, `state_flag_decode`: a purely combinational, fully specified 2-bit state-to-flag case with a default arm.
- The top level instantiates `state_flag_decode` on next-state and registers its output.
- The FSM, counter and `len_q` register stay in the top level.

## Test plan
- Reset, then idle 5 cycles → `curr_state`=0, `flag`=2, `busy`=0, `done`=0 throughout.
- `start`, `run_len`=4, ARM_CYCLES=2 → states 1,1,2,2,2,2,3,0; `flag` 2,2,1,1,1,1,0,2; `done` high only at cycle 7 after start.
- `start`, `run_len`=0 → ARM for 2 cycles, then DONE, then IDLE; RUN never visited.
- `abort` on the 2nd RUN cycle with `run_len`=10 → IDLE next cycle, `done` never asserted, `flag`=2.
- `start` held high continuously with `run_len`=1 → a relaunch every 5 cycles; `start` changes during ARM/RUN have no effect.
- `rst` pulsed mid-RUN, and `start`+`abort` together in IDLE → all outputs at reset values next cycle; no ARM entry.
